// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl_if
// Brief   : Decode/EX/MEM/WB side-band bundle for the hazard controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if #(
    parameter int REG_W  = 5,
    parameter int XLEN   = 64,
    parameter int PERF_W = 32
) ();
    logic              id_valid;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_W-1:0]  id_rd;
    logic              id_rd_wen;
    logic              id_is_load;
    logic              id_is_ecall;
    logic              ex_ready;
    logic              id_issue;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_wen;
    logic              ex_is_load;
    logic [XLEN-1:0]   ex_res;
    logic              ld_done;
    logic [REG_W-1:0]  ld_rd;
    logic              wb_wen;
    logic [REG_W-1:0]  wb_rd;
    logic [XLEN-1:0]   wb_val;
    logic [XLEN-1:0]   rf_val1;
    logic [XLEN-1:0]   rf_val2;
    logic [XLEN-1:0]   fwd_val1;
    logic [XLEN-1:0]   fwd_val2;
    logic              jump_valid;
    logic [XLEN-1:0]   jump_pc;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              flush;
    logic              ecall_done;
    logic [1:0]        state_o;
    logic              sb_err;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    // Core pipeline side
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_rd_wen, id_is_load, id_is_ecall, ex_ready, ex_rd, ex_wen,
               ex_is_load, ex_res, ld_done, ld_rd, wb_wen, wb_rd, wb_val,
               rf_val1, rf_val2, jump_valid, jump_pc, ecall_done,
        input  id_issue, fwd_val1, fwd_val2, redirect_valid, redirect_pc,
               flush, state_o, sb_err, stall_cnt, flush_cnt
    );

    // Hazard controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_rd_wen, id_is_load, id_is_ecall, ex_ready, ex_rd, ex_wen,
               ex_is_load, ex_res, ld_done, ld_rd, wb_wen, wb_rd, wb_val,
               rf_val1, rf_val2, jump_valid, jump_pc, ecall_done,
        output id_issue, fwd_val1, fwd_val2, redirect_valid, redirect_pc,
               flush, state_o, sb_err, stall_cnt, flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Load-use scoreboard, operand forwarding, jump flush and ecall
//           serialisation for the in-order five-stage core.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int REG_W        = 5,
    parameter int XLEN         = 64,
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH      = 2'd1,
        ST_ECALL_WAIT = 2'd2
    } state_t;

    localparam int               c_FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_FC_W-1:0] c_FC_LAST = c_FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_FC_W-1:0] r_fcnt;
    logic [c_FC_W-1:0] w_fcnt_next;
    logic [CNT_W-1:0]  r_pending [NUM_REGS];
    logic              r_jump_applied;
    logic              r_redirect_valid;
    logic [XLEN-1:0]   r_redirect_pc;
    logic              r_flush;
    logic              r_sb_err;
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    logic              w_new_jump;
    logic              w_accept_jump;
    logic              w_rs1_busy;
    logic              w_rs2_busy;
    logic              w_rd_sat;
    logic              w_hazard;
    logic              w_issue;
    logic              w_ld_inc;
    logic              w_ld_dec;
    logic              w_underflow;
    logic [XLEN-1:0]   w_fwd1;
    logic [XLEN-1:0]   w_fwd2;

    // ------------------------------------------------------------------
    // Hazard detection and issue
    // ------------------------------------------------------------------
    assign w_new_jump  = bus.jump_valid && !r_jump_applied;
    assign w_rs1_busy  = bus.id_rs1_used && (r_pending[bus.id_rs1] != '0);
    assign w_rs2_busy  = bus.id_rs2_used && (r_pending[bus.id_rs2] != '0);
    // A further load to a register whose counter is full would overflow it
    assign w_rd_sat    = bus.id_is_load && bus.id_rd_wen && (bus.id_rd != '0)
                         && (r_pending[bus.id_rd] == c_CNT_MAX);
    assign w_hazard    = w_rs1_busy || w_rs2_busy || w_rd_sat;
    assign w_issue     = bus.id_valid && bus.ex_ready && (r_state == ST_RUN)
                         && !w_hazard && !w_new_jump;

    assign w_ld_inc    = w_issue && bus.id_is_load && bus.id_rd_wen && (bus.id_rd != '0);
    assign w_ld_dec    = bus.ld_done && (bus.ld_rd != '0);
    assign w_underflow = w_ld_dec && (r_pending[bus.ld_rd] == '0);

    // ------------------------------------------------------------------
    // Pending-load scoreboard; entry 0 stays at zero forever
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_pending[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_ld_inc && (bus.id_rd == REG_W'(r))
                    && !(w_ld_dec && (bus.ld_rd == REG_W'(r)))) begin
                    r_pending[r] <= r_pending[r] + 1'b1;
                end else if (w_ld_dec && (bus.ld_rd == REG_W'(r))
                             && !(w_ld_inc && (bus.id_rd == REG_W'(r)))
                             && (r_pending[r] != '0)) begin
                    r_pending[r] <= r_pending[r] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding; loads in EX have no result yet
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd1 = bus.rf_val1;
        if (bus.id_rs1 == '0) begin
            w_fwd1 = '0;
        end else if (bus.ex_wen && !bus.ex_is_load && (bus.ex_rd == bus.id_rs1)) begin
            w_fwd1 = bus.ex_res;
        end else if (bus.wb_wen && (bus.wb_rd == bus.id_rs1)) begin
            w_fwd1 = bus.wb_val;
        end
    end

    always_comb begin
        w_fwd2 = bus.rf_val2;
        if (bus.id_rs2 == '0) begin
            w_fwd2 = '0;
        end else if (bus.ex_wen && !bus.ex_is_load && (bus.ex_rd == bus.id_rs2)) begin
            w_fwd2 = bus.ex_res;
        end else if (bus.wb_wen && (bus.wb_rd == bus.id_rs2)) begin
            w_fwd2 = bus.wb_val;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_fcnt_next   = r_fcnt;
        w_accept_jump = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_new_jump) begin
                    w_accept_jump = 1'b1;
                    w_state_next  = ST_FLUSH;
                    w_fcnt_next   = c_FC_LAST;
                end else if (w_issue && bus.id_is_ecall) begin
                    w_state_next  = ST_ECALL_WAIT;
                end
            end
            ST_FLUSH: begin
                if (r_fcnt == '0) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_fcnt_next  = r_fcnt - 1'b1;
                end
            end
            ST_ECALL_WAIT: begin
                if (bus.ecall_done) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= ST_RUN;
            r_fcnt           <= '0;
            r_jump_applied   <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_sb_err         <= 1'b0;
            r_stall_cnt      <= '0;
            r_flush_cnt      <= '0;
        end else begin
            r_state          <= w_state_next;
            r_fcnt           <= w_fcnt_next;
            r_redirect_valid <= w_accept_jump;
            r_flush          <= (w_state_next == ST_FLUSH);
            if (w_accept_jump) begin
                r_redirect_pc <= bus.jump_pc;
            end
            // One redirect per jump: re-arm only once EX drops jump_valid
            if (!bus.jump_valid) begin
                r_jump_applied <= 1'b0;
            end else if (w_accept_jump) begin
                r_jump_applied <= 1'b1;
            end
            if (w_underflow) begin
                r_sb_err <= 1'b1;
            end
            if (bus.id_valid && !w_issue) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_accept_jump) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.id_issue       = w_issue;
    assign bus.fwd_val1       = w_fwd1;
    assign bus.fwd_val2       = w_fwd2;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush          = r_flush;
    assign bus.state_o        = r_state;
    assign bus.sb_err         = r_sb_err;
    assign bus.stall_cnt      = r_stall_cnt;
    assign bus.flush_cnt      = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Scoreboard bench for pipeline_hazard_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int S_ISSUE = 0, S_FWD1 = 1, S_FWD2 = 2, S_FLUSH = 3, S_RV = 4,
                   S_STATE = 5, S_ERR = 6, S_STALL = 7, S_FCNT = 8;

    typedef struct {
        string       tag;
        int          sig;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(5), .XLEN(64), .PERF_W(32)) hif ();

    pipeline_hazard_ctrl #(
        .NUM_REGS(32), .REG_W(5), .XLEN(64), .CNT_W(2), .FLUSH_CYCLES(2), .PERF_W(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    exp_t        exp_q[$];
    logic [63:0] redir_q[$];
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          m_stall = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] observe(input int sig);
        case (sig)
            S_ISSUE: return 64'(hif.id_issue);
            S_FWD1:  return hif.fwd_val1;
            S_FWD2:  return hif.fwd_val2;
            S_FLUSH: return 64'(hif.flush);
            S_RV:    return 64'(hif.redirect_valid);
            S_STATE: return 64'(hif.state_o);
            S_ERR:   return 64'(hif.sb_err);
            S_STALL: return 64'(hif.stall_cnt);
            default: return 64'(hif.flush_cnt);
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Every cycle goes through here so the stall model tracks id_valid exactly
    task automatic expect_issue(input string tag, input bit v);
        push({tag, "_issue"}, S_ISSUE, 64'(v));
        push({tag, "_stall"}, S_STALL, 64'(m_stall));
        if (hif.id_valid && !v) m_stall++;
    endtask

    task automatic settle();
        exp_t e;
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic no_ins();
        hif.id_valid    = 1'b0;
        hif.id_is_load  = 1'b0;
        hif.id_is_ecall = 1'b0;
        hif.id_rd_wen   = 1'b0;
        hif.id_rs1_used = 1'b0;
        hif.id_rs2_used = 1'b0;
        hif.id_rs1      = '0;
        hif.id_rs2      = '0;
        hif.id_rd       = '0;
    endtask

    task automatic load_ins(input logic [4:0] rd);
        no_ins();
        hif.id_valid   = 1'b1;
        hif.id_is_load = 1'b1;
        hif.id_rd_wen  = 1'b1;
        hif.id_rd      = rd;
    endtask

    task automatic alu_ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        no_ins();
        hif.id_valid    = 1'b1;
        hif.id_rs1      = rs1;
        hif.id_rs2      = rs2;
        hif.id_rs1_used = 1'b1;
        hif.id_rs2_used = 1'b1;
        hif.id_rd       = rd;
        hif.id_rd_wen   = 1'b1;
    endtask

    task automatic idle();
        no_ins();
        hif.ex_ready   = 1'b1;
        hif.ex_rd      = '0;
        hif.ex_wen     = 1'b0;
        hif.ex_is_load = 1'b0;
        hif.ex_res     = '0;
        hif.ld_done    = 1'b0;
        hif.ld_rd      = '0;
        hif.wb_wen     = 1'b0;
        hif.wb_rd      = '0;
        hif.wb_val     = '0;
        hif.rf_val1    = '0;
        hif.rf_val2    = '0;
        hif.jump_valid = 1'b0;
        hif.jump_pc    = '0;
        hif.ecall_done = 1'b0;
    endtask

    // Redirect pulses are matched against targets queued when the jump was driven
    always @(negedge clk) begin
        if (hif.redirect_valid === 1'b1) begin
            if (redir_q.size() == 0) check_val("redirect_unexpected", 64'(hif.redirect_valid), 64'd0);
            else                     check_val("redirect_pc", hif.redirect_pc, redir_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        push("rst_state", S_STATE, 0); push("rst_flush", S_FLUSH, 0);
        push("rst_rv", S_RV, 0);       push("rst_err", S_ERR, 0);
        push("rst_stall", S_STALL, 0); push("rst_fcnt", S_FCNT, 0);
        settle();
        reset = 1'b1;

        // Load-use stall on x5
        next_cycle(); load_ins(5);      expect_issue("t1_ld", 1);      settle();
        next_cycle(); alu_ins(5, 0, 6); hif.id_rs2_used = 1'b0;
                                        expect_issue("t1_stall_a", 0); settle();
        next_cycle();                   expect_issue("t1_stall_b", 0); settle();
        next_cycle(); hif.ld_done = 1'b1; hif.ld_rd = 5;
                                        expect_issue("t1_stall_c", 0); settle();
        next_cycle(); hif.ld_done = 1'b0; expect_issue("t1_go", 1);    settle();
        next_cycle(); no_ins();         expect_issue("t1_idle", 0);    settle();

        // Counter saturation on x7
        for (int i = 0; i < 3; i++) begin
            next_cycle(); load_ins(7); expect_issue($sformatf("t2_ld%0d", i), 1); settle();
        end
        next_cycle();                   expect_issue("t2_sat", 0);      settle();
        next_cycle(); hif.ld_done = 1'b1; hif.ld_rd = 7;
                                        expect_issue("t2_sat_done", 0); settle();
        next_cycle();                   expect_issue("t2_inc_dec", 1);  settle();
        next_cycle(); hif.ld_done = 1'b0; expect_issue("t2_refill", 1); settle();
        next_cycle();                   expect_issue("t2_sat2", 0);     settle();
        for (int i = 0; i < 3; i++) begin
            next_cycle(); no_ins(); hif.ld_done = 1'b1; hif.ld_rd = 7;
            expect_issue($sformatf("t2_drain%0d", i), 0); settle();
        end
        next_cycle(); hif.ld_done = 1'b0; load_ins(0);
        expect_issue("t2_x0_ld0", 1); push("t2_no_err", S_ERR, 0); settle();
        for (int i = 1; i < 4; i++) begin
            next_cycle(); expect_issue($sformatf("t2_x0_ld%0d", i), 1); settle();
        end
        next_cycle(); alu_ins(0, 0, 1); hif.ld_done = 1'b1; hif.ld_rd = 0;
        expect_issue("t2_x0_read", 1); settle();
        next_cycle(); no_ins(); hif.ld_done = 1'b0;
        expect_issue("t2_idle", 0); push("t2_x0_done_no_err", S_ERR, 0); settle();

        // Forwarding priority
        next_cycle(); expect_issue("t3", 0);
        hif.ex_wen = 1'b1; hif.ex_is_load = 1'b0; hif.ex_rd = 3; hif.ex_res = 64'hAA;
        hif.wb_wen = 1'b1; hif.wb_rd = 3; hif.wb_val = 64'hBB;
        hif.rf_val1 = 64'hCC; hif.rf_val2 = 64'hDD; hif.id_rs1 = 3; hif.id_rs2 = 3;
        push("t3_ex_fwd1", S_FWD1, 64'hAA); push("t3_ex_fwd2", S_FWD2, 64'hAA); settle();
        hif.ex_is_load = 1'b1;
        push("t3_wb_fwd1", S_FWD1, 64'hBB); settle();
        next_cycle(); expect_issue("t3b", 0);
        hif.wb_rd = 4; hif.id_rs2 = 4;
        push("t3_rf_fwd1", S_FWD1, 64'hCC); push("t3_wb_fwd2", S_FWD2, 64'hBB); settle();
        hif.ex_is_load = 1'b0; hif.ex_rd = 0; hif.wb_rd = 0; hif.id_rs1 = 0;
        push("t3_x0_fwd1", S_FWD1, 64'h0); push("t3_rf_fwd2", S_FWD2, 64'hDD); settle();
        idle();

        // Jump flush, FLUSH_CYCLES = 2
        next_cycle(); alu_ins(1, 2, 3); hif.jump_valid = 1'b1; hif.jump_pc = 64'h1000;
        redir_q.push_back(64'h1000);
        expect_issue("t4_j0", 0); push("t4_j0_flush", S_FLUSH, 0);
        push("t4_j0_rv", S_RV, 0); push("t4_j0_state", S_STATE, 0); settle();
        next_cycle(); expect_issue("t4_j1", 0); push("t4_j1_flush", S_FLUSH, 1);
        push("t4_j1_rv", S_RV, 1); push("t4_j1_state", S_STATE, 1); settle();
        next_cycle(); expect_issue("t4_j2", 0); push("t4_j2_flush", S_FLUSH, 1);
        push("t4_j2_rv", S_RV, 0); push("t4_j2_state", S_STATE, 1); settle();
        next_cycle(); hif.jump_valid = 1'b0;
        expect_issue("t4_j3", 1); push("t4_j3_flush", S_FLUSH, 0);
        push("t4_j3_rv", S_RV, 0); push("t4_j3_state", S_STATE, 0);
        push("t4_fcnt", S_FCNT, 1); settle();
        next_cycle(); no_ins(); expect_issue("t4_idle", 0); settle();

        // Ecall serialisation
        next_cycle(); no_ins(); hif.id_valid = 1'b1; hif.id_is_ecall = 1'b1;
        expect_issue("t5_e0", 1); push("t5_e0_state", S_STATE, 0); settle();
        for (int i = 1; i <= 4; i++) begin
            next_cycle(); alu_ins(1, 2, 3); hif.ecall_done = (i == 4);
            expect_issue($sformatf("t5_w%0d", i), 0);
            push($sformatf("t5_w%0d_state", i), S_STATE, 2); settle();
        end
        next_cycle(); hif.ecall_done = 1'b0;
        expect_issue("t5_run", 1); push("t5_run_state", S_STATE, 0); settle();
        next_cycle(); no_ins(); expect_issue("t5_idle", 0); settle();

        // Reset in the middle of a flush
        next_cycle(); load_ins(9); expect_issue("t6_ld1", 1); settle();
        next_cycle();              expect_issue("t6_ld2", 1); settle();
        next_cycle(); no_ins(); hif.jump_valid = 1'b1; hif.jump_pc = 64'h2000;
        redir_q.push_back(64'h2000);
        expect_issue("t6_j0", 0); settle();
        next_cycle(); expect_issue("t6_j1", 0); push("t6_j1_state", S_STATE, 1);
        push("t6_j1_flush", S_FLUSH, 1); push("t6_j1_fcnt", S_FCNT, 2); settle();
        reset = 1'b0; hif.jump_valid = 1'b0;
        next_cycle(); reset = 1'b1; m_stall = 0;
        expect_issue("t6_post", 0); push("t6_post_state", S_STATE, 0);
        push("t6_post_flush", S_FLUSH, 0); push("t6_post_rv", S_RV, 0);
        push("t6_post_fcnt", S_FCNT, 0); push("t6_post_err", S_ERR, 0); settle();
        next_cycle(); alu_ins(9, 0, 1); hif.ld_done = 1'b1; hif.ld_rd = 9;
        expect_issue("t6_x9_free", 1); push("t6_pre_err", S_ERR, 0); settle();
        next_cycle(); no_ins(); hif.ld_done = 1'b0;
        expect_issue("t6_err", 0); push("t6_err_set", S_ERR, 1); settle();
        next_cycle(); expect_issue("t6_sticky", 0); push("t6_err_sticky", S_ERR, 1); settle();

        check_val("redir_q_empty", 64'(redir_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
